// File: rtl/cache_pkg.sv
// Shared types for the cache writeback path: FSM encoding, block status bits and
// data-array chip enables.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        SEND  = 2'd2,
        CLEAN = 2'd3
    } wb_state_t;

    typedef struct packed {
        logic valid;
        logic dirty;
    } status_packet_t;

    typedef struct packed {
        logic valid;
        logic tag;
        logic data;
        logic dirty;
    } data_enable_t;

    localparam status_packet_t STATUS_CLEAN = '{valid: 1'b1, dirty: 1'b0};

    function automatic logic needs_writeback(input status_packet_t s);
        return s.valid & s.dirty;
    endfunction

endpackage

// File: rtl/cache_writeback_ctrl.sv
// Writes a dirty victim block to memory word by word, then marks the line clean.
// Latency: first beat 2 cycles after evict_i; 2 cycles/word, or 1 cycle/word with CACHE_WB_PREFETCH_EN.
// Backpressure: mem_ready_i low holds the current beat stable; evict_i is ignored while busy_o.
module cache_writeback_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int BLOCK_WORDS = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           evict_i,
    input  logic [ADDR_WIDTH-1:0]          evict_address_i,
    input  status_packet_t                 evict_status_i,
    output logic                           busy_o,
    output logic                           done_o,
    output data_enable_t                   cache_enable_o,
    output logic [$clog2(BLOCK_WORDS)-1:0] cache_offset_o,
    output status_packet_t                 cache_status_o,
    input  logic [DATA_WIDTH-1:0]          cache_data_i,
    output logic                           mem_valid_o,
    output logic [ADDR_WIDTH-1:0]          mem_address_o,
    output logic [DATA_WIDTH-1:0]          mem_data_o,
    output logic                           mem_last_o,
    input  logic                           mem_ready_i
);

    localparam int OFF_W      = $clog2(BLOCK_WORDS);
    localparam int BYTE_SHIFT = $clog2(DATA_WIDTH / 8);
    localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(BLOCK_WORDS - 1);

    wb_state_t             state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [OFF_W-1:0]      beat_off_q, beat_off_d;
    logic [OFF_W-1:0]      cache_off_q, cache_off_d;
    logic                  en_data_q, en_data_d;
    logic                  en_dirty_q, en_dirty_d;
    status_packet_t        status_q, status_d;
    logic                  mem_vld_q, mem_vld_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_dat_q, mem_dat_d;
    logic                  mem_last_q, mem_last_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
`ifdef CACHE_WB_PREFETCH_EN
    logic                  pf_vld_q, pf_vld_d;
    logic [DATA_WIDTH-1:0] pf_dat_q, pf_dat_d;
`endif

    logic             handshake;
    logic [OFF_W-1:0] nxt_off;

    assign handshake = mem_vld_q & mem_ready_i;
    assign nxt_off   = beat_off_q + OFF_W'(1);

    function automatic logic [ADDR_WIDTH-1:0] beat_addr(input logic [ADDR_WIDTH-1:0] base,
                                                        input logic [OFF_W-1:0]      off);
        return base + (ADDR_WIDTH'(off) << BYTE_SHIFT);
    endfunction

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        beat_off_d  = beat_off_q;
        cache_off_d = cache_off_q;
        en_data_d   = en_data_q;
        en_dirty_d  = en_dirty_q;
        status_d    = status_q;
        mem_vld_d   = mem_vld_q;
        mem_addr_d  = mem_addr_q;
        mem_dat_d   = mem_dat_q;
        mem_last_d  = mem_last_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
`ifdef CACHE_WB_PREFETCH_EN
        pf_vld_d    = pf_vld_q;
        pf_dat_d    = pf_dat_q;
`endif
        case (state_q)
            IDLE: begin
                if (evict_i) begin
                    if (needs_writeback(evict_status_i)) begin
                        state_d     = READ;
                        base_d      = evict_address_i;
                        beat_off_d  = '0;
                        cache_off_d = '0;
                        en_data_d   = 1'b1;
                        busy_d      = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            READ: begin
                en_data_d  = 1'b0;
                mem_vld_d  = 1'b1;
                mem_dat_d  = cache_data_i;
                mem_addr_d = beat_addr(base_q, beat_off_q);
                mem_last_d = (beat_off_q == LAST_OFF);
                state_d    = SEND;
`ifdef CACHE_WB_PREFETCH_EN
                // Start fetching the following word while this one is on the bus.
                if (beat_off_q != LAST_OFF) begin
                    en_data_d   = 1'b1;
                    cache_off_d = nxt_off;
                end
`endif
            end
            SEND: begin
                if (handshake) begin
                    if (mem_last_q) begin
                        mem_vld_d  = 1'b0;
                        mem_last_d = 1'b0;
                        beat_off_d = '0;
                        en_dirty_d = 1'b1;
                        status_d   = STATUS_CLEAN;
                        done_d     = 1'b1;
                        state_d    = CLEAN;
                    end else begin
                        beat_off_d = nxt_off;
`ifdef CACHE_WB_PREFETCH_EN
                        if (pf_vld_q || en_data_q) begin
                            mem_dat_d  = pf_vld_q ? pf_dat_q : cache_data_i;
                            mem_addr_d = beat_addr(base_q, nxt_off);
                            mem_last_d = (nxt_off == LAST_OFF);
                            pf_vld_d   = 1'b0;
                            en_data_d  = (nxt_off != LAST_OFF);
                            cache_off_d = nxt_off + OFF_W'(1);
                        end else begin
                            mem_vld_d   = 1'b0;
                            en_data_d   = 1'b1;
                            cache_off_d = nxt_off;
                            state_d     = READ;
                        end
`else
                        mem_vld_d   = 1'b0;
                        en_data_d   = 1'b1;
                        cache_off_d = nxt_off;
                        state_d     = READ;
`endif
                    end
                end
`ifdef CACHE_WB_PREFETCH_EN
                // Stalled with a read in flight: park the word until the bus frees up.
                else if (en_data_q) begin
                    pf_dat_d  = cache_data_i;
                    pf_vld_d  = 1'b1;
                    en_data_d = 1'b0;
                end
`endif
            end
            CLEAN: begin
                en_dirty_d = 1'b0;
                status_d   = '0;
                busy_d     = 1'b0;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            base_q      <= '0;
            beat_off_q  <= '0;
            cache_off_q <= '0;
            en_data_q   <= 1'b0;
            en_dirty_q  <= 1'b0;
            status_q    <= '0;
            mem_vld_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_dat_q   <= '0;
            mem_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef CACHE_WB_PREFETCH_EN
            pf_vld_q    <= 1'b0;
            pf_dat_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            beat_off_q  <= beat_off_d;
            cache_off_q <= cache_off_d;
            en_data_q   <= en_data_d;
            en_dirty_q  <= en_dirty_d;
            status_q    <= status_d;
            mem_vld_q   <= mem_vld_d;
            mem_addr_q  <= mem_addr_d;
            mem_dat_q   <= mem_dat_d;
            mem_last_q  <= mem_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef CACHE_WB_PREFETCH_EN
            pf_vld_q    <= pf_vld_d;
            pf_dat_q    <= pf_dat_d;
`endif
        end
    end

    always_comb begin
        cache_enable_o       = '0;
        cache_enable_o.data  = en_data_q;
        cache_enable_o.dirty = en_dirty_q;
    end

    assign cache_offset_o = cache_off_q;
    assign cache_status_o = status_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign mem_valid_o    = mem_vld_q;
    assign mem_address_o  = mem_addr_q;
    assign mem_data_o     = mem_dat_q;
    assign mem_last_o     = mem_last_q;

endmodule

// File: tb/tb_cache_writeback_ctrl.sv
// Directed bench for cache_writeback_ctrl: table of evictions plus reset-abort and
// eviction-while-busy sequences.
module tb_cache_writeback_ctrl;
    import cache_pkg::*;

`ifdef CACHE_WB_PREFETCH_EN
    localparam int SP = 1;
`else
    localparam int SP = 2;
`endif
    localparam int DLAT = 3 + 3 * SP;

    logic           clk = 1'b0;
    logic           rst_i;
    logic           evict_i;
    logic [31:0]    evict_address_i;
    status_packet_t evict_status_i;
    logic           busy_o;
    logic           done_o;
    data_enable_t   cache_enable_o;
    logic [1:0]     cache_offset_o;
    status_packet_t cache_status_o;
    logic [31:0]    cache_data_i;
    logic           mem_valid_o;
    logic [31:0]    mem_address_o;
    logic [31:0]    mem_data_o;
    logic           mem_last_o;
    logic           mem_ready_i;

    cache_writeback_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .BLOCK_WORDS(4)) dut (
        .clk_i(clk), .rst_i(rst_i), .evict_i(evict_i), .evict_address_i(evict_address_i),
        .evict_status_i(evict_status_i), .busy_o(busy_o), .done_o(done_o),
        .cache_enable_o(cache_enable_o), .cache_offset_o(cache_offset_o),
        .cache_status_o(cache_status_o), .cache_data_i(cache_data_i),
        .mem_valid_o(mem_valid_o), .mem_address_o(mem_address_o), .mem_data_o(mem_data_o),
        .mem_last_o(mem_last_o), .mem_ready_i(mem_ready_i)
    );

    always #5 clk = ~clk;

    // Cache array model: the word at the enabled offset is sampled on the next edge.
    logic [31:0] words [4];
    assign cache_data_i = cache_enable_o.data ? words[cache_offset_o] : 32'hDEAD_BEEF;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] b_addr[$];
    logic [31:0] b_data[$];
    logic        b_last[$];
    int          b_cyc[$];
    int          done_cyc[$];
    int          en_cnt, clean_cnt, vld_cnt, hold_err, inv_err = 0;
    logic [1:0]  clean_status;
    logic        clean_done;
    logic        prev_stall = 1'b0;
    logic [64:0] prev_beat;

    always @(negedge clk) begin
        if (cache_enable_o.valid || cache_enable_o.tag) inv_err++;
        if (rst_i) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (!mem_valid_o || {mem_address_o, mem_data_o, mem_last_o} != prev_beat))
                hold_err++;
            prev_stall = mem_valid_o && !mem_ready_i;
            prev_beat  = {mem_address_o, mem_data_o, mem_last_o};
            if (mem_valid_o) vld_cnt++;
            if (mem_valid_o && mem_ready_i) begin
                b_addr.push_back(mem_address_o);
                b_data.push_back(mem_data_o);
                b_last.push_back(mem_last_o);
                b_cyc.push_back(cyc);
            end
            if (done_o) done_cyc.push_back(cyc);
            if (cache_enable_o.data) en_cnt++;
            if (cache_enable_o.dirty) begin
                clean_cnt++;
                clean_status = cache_status_o;
                clean_done   = done_o;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_logs();
        b_addr.delete(); b_data.delete(); b_last.delete(); b_cyc.delete(); done_cyc.delete();
        en_cnt = 0; clean_cnt = 0; vld_cnt = 0; hold_err = 0;
        clean_status = 2'b00; clean_done = 1'b0;
    endtask

    task automatic pulse_evict(input logic [31:0] addr, input logic v, input logic d, output int ev);
        @(posedge clk); #1;
        evict_i = 1'b1; evict_address_i = addr;
        evict_status_i = '{valid: v, dirty: d};
        ev = cyc;
        @(posedge clk); #1;
        evict_i = 1'b0; evict_status_i = '0;
    endtask

    typedef struct {
        logic [31:0] addr;
        logic        valid;
        logic        dirty;
        logic [31:0] d0;
        int          stall_beat;
        int          stall_n;
        int          exp_beats;
        int          exp_lat;
    } vec_t;

    vec_t vecs[6];

    task automatic run_row(input int r);
        vec_t v = vecs[r];
        int ev, stalled;
        logic [31:0] sa;
        for (int i = 0; i < 4; i++) words[i] = v.d0 + 32'(i);
        clear_logs();
        mem_ready_i = 1'b1;
        pulse_evict(v.addr, v.valid, v.dirty, ev);
        check($sformatf("row%0d busy", r), busy_o, v.valid & v.dirty);
        stalled = 0;
        sa = v.addr + 32'(4 * v.stall_beat);
        for (int n = 0; n < 60 && done_cyc.size() == 0; n++) begin
            if (mem_valid_o && mem_address_o == sa && stalled < v.stall_n) begin
                mem_ready_i = 1'b0;
                stalled++;
            end else begin
                mem_ready_i = 1'b1;
            end
            @(posedge clk); #1;
        end
        mem_ready_i = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check($sformatf("row%0d done count", r), done_cyc.size(), 1);
        if (done_cyc.size() > 0)
            check($sformatf("row%0d done latency", r), done_cyc[0] - ev, v.exp_lat);
        check($sformatf("row%0d beat count", r), b_addr.size(), v.exp_beats);
        for (int i = 0; i < v.exp_beats && i < b_addr.size(); i++) begin
            check($sformatf("row%0d beat%0d addr", r, i), b_addr[i], v.addr + 32'(4 * i));
            check($sformatf("row%0d beat%0d data", r, i), b_data[i], v.d0 + 32'(i));
            check($sformatf("row%0d beat%0d last", r, i), b_last[i], i == 3);
            check($sformatf("row%0d beat%0d cycle", r, i), b_cyc[i] - ev,
                  2 + i * SP + (i >= v.stall_beat ? v.stall_n : 0));
        end
        check($sformatf("row%0d valid cycles", r), vld_cnt, v.exp_beats + v.stall_n);
        check($sformatf("row%0d data enables", r), en_cnt, v.exp_beats);
        check($sformatf("row%0d dirty enables", r), clean_cnt, v.exp_beats > 0);
        if (v.valid && v.dirty) begin
            check($sformatf("row%0d clean status", r), clean_status, 2'b10);
            check($sformatf("row%0d clean with done", r), clean_done, 1'b1);
        end
        check($sformatf("row%0d hold stable", r), hold_err, 0);
        check($sformatf("row%0d busy after", r), busy_o, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int ev;
        logic found;

        vecs[0] = '{32'h0000_1000, 1'b1, 1'b1, 32'h0000_00A0, 0, 0, 4, DLAT};
        vecs[1] = '{32'h0000_2000, 1'b1, 1'b0, 32'h0000_00B0, 0, 0, 0, 1};
        vecs[2] = '{32'h0000_3000, 1'b0, 1'b1, 32'h0000_00C0, 0, 0, 0, 1};
        vecs[3] = '{32'hFFFF_FFF0, 1'b1, 1'b1, 32'h5A5A_0000, 0, 0, 4, DLAT};
        vecs[4] = '{32'h0000_1000, 1'b1, 1'b1, 32'h0000_00A0, 1, 3, 4, DLAT + 3};
        vecs[5] = '{32'h0000_0040, 1'b0, 1'b0, 32'h0000_00D0, 0, 0, 0, 1};

        rst_i = 1'b1; evict_i = 1'b0; evict_address_i = '0; evict_status_i = '0;
        mem_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) words[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", busy_o, 1'b0);
        check("reset done", done_o, 1'b0);
        check("reset mem_valid", mem_valid_o, 1'b0);
        check("reset mem_last", mem_last_o, 1'b0);
        check("reset enable", cache_enable_o, 4'b0);
        check("reset status", cache_status_o, 2'b0);
        check("reset mem_address", mem_address_o, 32'h0);
        check("reset mem_data", mem_data_o, 32'h0);
        rst_i = 1'b0;

        for (int r = 0; r < 6; r++) run_row(r);

        // Reset in the middle of the third beat aborts the block silently.
        for (int i = 0; i < 4; i++) words[i] = 32'hA0 + 32'(i);
        clear_logs();
        mem_ready_i = 1'b1;
        pulse_evict(32'h1000, 1'b1, 1'b1, ev);
        found = 1'b0;
        for (int n = 0; n < 40 && !found; n++) begin
            @(posedge clk); #1;
            if (mem_valid_o && mem_address_o == 32'h1008) found = 1'b1;
        end
        check("abort reach beat3", found, 1'b1);
        rst_i = 1'b1;
        @(posedge clk); #1;
        check("abort busy", busy_o, 1'b0);
        check("abort done", done_o, 1'b0);
        check("abort mem_valid", mem_valid_o, 1'b0);
        check("abort mem_last", mem_last_o, 1'b0);
        check("abort enable", cache_enable_o, 4'b0);
        check("abort status", cache_status_o, 2'b0);
        check("abort mem_address", mem_address_o, 32'h0);
        check("abort mem_data", mem_data_o, 32'h0);
        rst_i = 1'b0;
        clear_logs();
        repeat (12) @(posedge clk);
        #1;
        check("abort no done", done_cyc.size(), 0);
        check("abort no beats", b_addr.size(), 0);
        run_row(0);

        // A second eviction while busy must be dropped.
        for (int i = 0; i < 4; i++) words[i] = 32'h70 + 32'(i);
        clear_logs();
        pulse_evict(32'h4000, 1'b1, 1'b1, ev);
        @(posedge clk); #1;
        check("busy at second evict", busy_o, 1'b1);
        evict_i = 1'b1; evict_address_i = 32'h5000;
        evict_status_i = '{valid: 1'b1, dirty: 1'b1};
        @(posedge clk); #1;
        evict_i = 1'b0; evict_status_i = '0;
        repeat (30) @(posedge clk);
        #1;
        check("double done count", done_cyc.size(), 1);
        check("double beat count", b_addr.size(), 4);
        if (b_addr.size() == 4) begin
            check("double beat0 addr", b_addr[0], 32'h4000);
            check("double beat3 addr", b_addr[3], 32'h400C);
            check("double beat3 data", b_data[3], 32'h73);
        end
        check("double dirty enables", clean_cnt, 1);

        check("enable valid/tag zero", inv_err, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_writeback_ctrl.md
CACHE_WRITEBACK_CTRL -- requirements
Module: cache_writeback_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 32: byte address width.
REQ-002 Parameter DATA_WIDTH, default 32: cache/memory word width.
REQ-003 Parameter BLOCK_WORDS, default 4: words per cache block, power of two, at least 2.
REQ-004 Port clk_i  in  1: single clock, all logic on rising edge.
REQ-005 Port rst_i  in  1: reset, synchronous and active-high.
REQ-006 Port evict_i  in  1: one-cycle request to write back the victim block.
REQ-007 Port evict_address_i  in  ADDR_WIDTH: block-aligned victim address.
REQ-008 Port evict_status_i  in  status_packet_t: victim valid/dirty bits.
REQ-009 Port busy_o  out  1: writeback in progress.
REQ-010 Port done_o  out  1: one-cycle pulse, eviction handled.
REQ-011 Port cache_enable_o  out  data_enable_t: chip enables toward the data cache arrays.
REQ-012 Port cache_offset_o  out  log2(BLOCK_WORDS): word offset being read.
REQ-013 Port cache_status_o  out  status_packet_t: status value written when enable.dirty is set.
REQ-014 Port cache_data_i  in  DATA_WIDTH: cache read data, valid one cycle after enable.data.
REQ-015 Ports mem_valid_o (out 1), mem_address_o (out ADDR_WIDTH), mem_data_o (out DATA_WIDTH), mem_last_o (out 1): memory write channel.
REQ-016 Port mem_ready_i  in  1: memory accepts the beat when mem_valid_o and mem_ready_i are both high.

Function
REQ-017 FSM states: IDLE, READ, SEND, CLEAN.
REQ-018 IDLE + evict_i with valid=1, dirty=1: latch address, offset=0, go to READ, busy_o=1 from the next cycle.
REQ-019 IDLE + evict_i with valid=0 or dirty=0: done_o=1 the next cycle, no memory beat, stay IDLE.
REQ-020 READ: cache_enable_o.data=1 for one cycle at cache_offset_o; next cycle capture cache_data_i into the word register and enter SEND.
REQ-021 SEND: mem_valid_o=1 holding address, data and last stable until the handshake.
- mem_address_o = latched base + offset*(DATA_WIDTH/8).
- mem_last_o = 1 only when offset = BLOCK_WORDS-1.
REQ-022 SEND handshake, not last: offset increments and the FSM returns to READ.
REQ-023 SEND handshake, last: go to CLEAN; offset wraps to 0.
REQ-024 CLEAN: one cycle with cache_enable_o.dirty=1 and cache_status_o={valid=1, dirty=0}; done_o=1 the same cycle; then IDLE with busy_o=0.
REQ-025 evict_i while busy_o=1 is ignored; upstream must wait for done_o.
REQ-026 mem_ready_i outside SEND has no effect.
REQ-027 cache_enable_o.valid and cache_enable_o.tag are always 0.

Reset
REQ-028 rst_i high at any clock edge, including mid-block: FSM=IDLE, offset=0.
REQ-029 Reset values of outputs: busy_o, done_o, mem_valid_o, mem_last_o, cache_enable_o and cache_status_o are all 0; mem_address_o and mem_data_o are 0.
REQ-030 A writeback aborted by reset is not resumed and produces no done_o.

Configuration
REQ-031 Macro CACHE_WB_PREFETCH_EN, when defined: the next word is read during SEND into a second register, so back-to-back beats sustain 1 word/cycle when mem_ready_i is held high.
- Block of 4 words: first beat 2 cycles after evict_i, last beat 5 cycles after evict_i.
REQ-032 CACHE_WB_PREFETCH_EN undefined: strict READ/SEND alternation at 2 cycles/word minimum; ports and state encoding are identical in both builds.

Structure
REQ-033 Enum wb_state_t (IDLE, READ, SEND, CLEAN) belongs in cache_pkg, alongside status_packet_t and data_enable_t.
REQ-034 Single module; no sub-module is warranted; the offset counter and word register(s) stay inline.

Verification
REQ-035 evict_i, address 0x1000, valid=1, dirty=1, data words 0xA0..0xA3, mem_ready_i=1 -> four beats at 0x1000/0x1004/0x1008/0x100C with data 0xA0..0xA3, mem_last_o on the fourth beat only, then CLEAN with cache_status_o={1,0}, done_o one pulse.
REQ-036 evict_i with dirty=0 -> done_o the next cycle, mem_valid_o never asserted, cache_enable_o stays 0.
REQ-037 mem_ready_i low for 3 cycles on beat 2 -> mem_address_o=0x1004 and its data held stable, no extra beats, total beats = 4.
REQ-038 rst_i asserted during beat 3 -> next cycle all outputs at reset values, no done_o; a fresh evict_i completes normally.
REQ-039 Second evict_i issued while busy_o=1 -> ignored: exactly one block of beats and one done_o.
REQ-040 With CACHE_WB_PREFETCH_EN and mem_ready_i=1 -> beats on 4 consecutive cycles; without the macro -> beats spaced 2 cycles apart.
